// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStall,
  input  logic              iFlush,
  input  logic              iValidID,
  input  logic [DATA_W-1:0] iPCID,
  input  logic [DATA_W-1:0] iImmID,
  input  logic [REG_W-1:0]  iRs1,
  input  logic [REG_W-1:0]  iRs2,
  input  logic [REG_W-1:0]  iRd,
  input  logic [DATA_W-1:0] iReadData1,
  input  logic [DATA_W-1:0] iReadData2,
  input  logic              iRegWriteID,
  input  logic              iMemReadID,
  input  logic              iWBRegWrite,
  input  logic [REG_W-1:0]  iWBReg,
  input  logic [DATA_W-1:0] iWBData,
  output logic              oValidEX,
  output logic [DATA_W-1:0] oPCEX,
  output logic [DATA_W-1:0] oImmEX,
  output logic [DATA_W-1:0] oRs1ValEX,
  output logic [DATA_W-1:0] oRs2ValEX,
  output logic [REG_W-1:0]  oRs1EX,
  output logic [REG_W-1:0]  oRs2EX,
  output logic [REG_W-1:0]  oRdEX,
  output logic              oRegWriteEX,
  output logic              oMemReadEX,
  output logic              oStallID,
  output logic [CNT_W-1:0]  oBubbleCnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] rs1Val_q, rs1Val_d;
  logic [DATA_W-1:0] rs2Val_q, rs2Val_d;
  logic [REG_W-1:0]  rs1_q, rs1_d;
  logic [REG_W-1:0]  rs2_q, rs2_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              regWrite_q, regWrite_d;
  logic              memRead_q, memRead_d;
  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              wbHit1;
  logic              wbHit2;
  logic              hazard;
  logic              cntSat;

  // A WB write in the same cycle would only reach the bank on the next edge,
  // so its data is taken directly here; x0 is hard-wired and never bypassed.
  assign wbHit1 = iWBRegWrite && (iWBReg != '0) && (iWBReg == iRs1);
  assign wbHit2 = iWBRegWrite && (iWBReg != '0) && (iWBReg == iRs2);
  assign op1    = wbHit1 ? iWBData : iReadData1;
  assign op2    = wbHit2 ? iWBData : iReadData2;

  assign hazard = valid_q && memRead_q && (rd_q != '0) && iValidID &&
                  ((rd_q == iRs1) || (rd_q == iRs2));

  assign oStallID = iStall | (hazard & ~iFlush);
  assign cntSat   = &bubbleCnt_q;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1Val_d    = rs1Val_q;
    rs2Val_d    = rs2Val_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    regWrite_d  = regWrite_q;
    memRead_d   = memRead_q;
    bubbleCnt_d = bubbleCnt_q;

    if (iFlush) begin
      valid_d    = 1'b0;
      regWrite_d = 1'b0;
      memRead_d  = 1'b0;
    end else if (!iStall) begin
      if (hazard) begin
        valid_d    = 1'b0;
        regWrite_d = 1'b0;
        memRead_d  = 1'b0;
        if (!cntSat) begin
          bubbleCnt_d = bubbleCnt_q + 1'b1;
        end
      end else begin
        valid_d    = iValidID;
        pc_d       = iPCID;
        imm_d      = iImmID;
        rs1Val_d   = op1;
        rs2Val_d   = op2;
        rs1_d      = iRs1;
        rs2_d      = iRs2;
        rd_d       = iRd;
        regWrite_d = iRegWriteID & iValidID;
        memRead_d  = iMemReadID & iValidID;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1Val_q    <= '0;
      rs2Val_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      regWrite_q  <= 1'b0;
      memRead_q   <= 1'b0;
      bubbleCnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1Val_q    <= rs1Val_d;
      rs2Val_q    <= rs2Val_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      regWrite_q  <= regWrite_d;
      memRead_q   <= memRead_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  assign oValidEX    = valid_q;
  assign oPCEX       = pc_q;
  assign oImmEX      = imm_q;
  assign oRs1ValEX   = rs1Val_q;
  assign oRs2ValEX   = rs2Val_q;
  assign oRs1EX      = rs1_q;
  assign oRs2EX      = rs2_q;
  assign oRdEX       = rd_q;
  assign oRegWriteEX = regWrite_q;
  assign oMemReadEX  = memRead_q;
  assign oBubbleCnt  = bubbleCnt_q;

endmodule
